// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM encoding, port ids and
// the byte-to-word address conversion used on the RAM side.
`ifndef DMEM_ARB_PKG_SV
`define DMEM_ARB_PKG_SV

// Drops the byte offset and zero-fills the top so the width is preserved.
`define DMEM_BYTE2WORD(a, w) {2'b00, a[(w)-1:2]}

package dmem_arb_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

`endif

// File: rtl/dmem_arb_prio.sv
// Combinational grant decision: port 0 wins by default, port 1 wins when
// port 0 is idle, when port 0 has starved it, or while it holds the lock.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             locked,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             gnt0,
  output logic             gnt1
);

  logic starve_hit;
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (locked) begin
      gnt1 = m1_req;
    end else if (m1_req && (!m0_req || starve_hit)) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = m0_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: fixed priority to the
// core, starvation guard and lockable bursts for the loader port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_wen,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_dout,
  input  logic                  m1_req,
  input  logic                  m1_wen,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_din,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_dout,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int LC_W = $clog2(LOCK_MAX + 1);

  arb_state_t      state, state_nxt;
  logic [SC_W-1:0] starve_cnt;
  logic [LC_W-1:0] lock_cnt;
  logic            prio_gnt0, prio_gnt1;
  logic            gnt0, gnt1;
  logic            rd_pend_p1, rd_owner_p1;
  logic            m0_vld_p1, m1_vld_p1;
  logic            addr_lsb_unused;

  assign addr_lsb_unused = ^{m0_addr[1:0], m1_addr[1:0]};

  dmem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (SC_W)
  ) u_prio (
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .locked    (state == LOCKED),
    .starve_cnt(starve_cnt),
    .gnt0      (prio_gnt0),
    .gnt1      (prio_gnt1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A lock ends when port 1 lets go, stops asking, or has used its budget.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt1 && m1_lock) state_nxt = LOCKED;
      LOCKED:  if (!m1_req || (gnt1 && (!m1_lock || lock_cnt == LC_W'(LOCK_MAX))))
                 state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0     = prio_gnt0 & ~rst;
    gnt1     = prio_gnt1 & ~rst;
    ram_we   = gnt1 ? m1_wen : (gnt0 & m0_wen);
    ram_addr = gnt1 ? `DMEM_BYTE2WORD(m1_addr, ADDR_WIDTH)
                    : `DMEM_BYTE2WORD(m0_addr, ADDR_WIDTH);
    ram_din  = gnt1 ? m1_din : m0_din;
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt1 || !m1_req) begin
      starve_cnt <= '0;
    end else if (gnt0 && starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (state == IDLE) begin
      lock_cnt <= (state_nxt == LOCKED) ? LC_W'(1) : '0;
    end else if (state_nxt == IDLE) begin
      lock_cnt <= '0;
    end else if (gnt1) begin
      lock_cnt <= lock_cnt + LC_W'(1);
    end
  end

  // ---- p0 -> p1: grant edge; read data returns from the RAM one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_p1  <= 1'b0;
      rd_owner_p1 <= PORT0;
      m0_vld_p1   <= 1'b0;
      m1_vld_p1   <= 1'b0;
    end else begin
      rd_pend_p1 <= (gnt0 & ~m0_wen) | (gnt1 & ~m1_wen);
      m0_vld_p1  <= gnt0 & ~m0_wen;
      m1_vld_p1  <= gnt1 & ~m1_wen;
      if (gnt0 || gnt1) rd_owner_p1 <= gnt1 ? PORT1 : PORT0;
    end
  end

  assign m0_rvalid = m0_vld_p1;
  assign m1_rvalid = m1_vld_p1;
  assign m0_dout   = (rd_pend_p1 && rd_owner_p1 == PORT0) ? ram_dout : '0;
  assign m1_dout   = (rd_pend_p1 && rd_owner_p1 == PORT1) ? ram_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data RAM whose
// unwritten words read back as 0xA000_0000 | word_index.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wen, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_din, m0_dout;
  logic        m1_req, m1_wen, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_din, m1_dout;
  logic        ram_we;
  logic [31:0] ram_addr, ram_din, ram_dout;

  logic        mem_clr;
  logic [31:0] mem     [0:63];
  logic        written [0:63];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(4),
    .LOCK_MAX    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_wen   (m0_wen),
    .m0_addr  (m0_addr),
    .m0_din   (m0_din),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_dout  (m0_dout),
    .m1_req   (m1_req),
    .m1_wen   (m1_wen),
    .m1_addr  (m1_addr),
    .m1_din   (m1_din),
    .m1_lock  (m1_lock),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_dout  (m1_dout),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Synchronous-read RAM model, one cycle of read latency.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) written[i] <= 1'b0;
    end else if (ram_we) begin
      mem[ram_addr[5:0]]     <= ram_din;
      written[ram_addr[5:0]] <= 1'b1;
    end
    ram_dout <= written[ram_addr[5:0]] ? mem[ram_addr[5:0]]
                                       : (32'hA000_0000 | {26'd0, ram_addr[5:0]});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst = 1'b1; mem_clr = 1'b1;
    m0_req = 0; m0_wen = 0; m0_addr = 0; m0_din = 0;
    m1_req = 0; m1_wen = 0; m1_addr = 0; m1_din = 0; m1_lock = 0;
    ram_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;

    // Reset: grants and write enable forced low even with requests present
    m0_req = 1; m0_wen = 1; m1_req = 1; m1_wen = 1;
    #1;
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    m0_req = 0; m0_wen = 0; m1_req = 0; m1_wen = 0;
    rst = 1'b0;
    tick();

    // Port 0 single read of byte 0x10 -> word 4
    m0_req = 1; m0_addr = 32'h10;
    #1;
    chk("rd0_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("rd0_gnt1", {31'd0, m1_gnt}, 32'd0);
    chk("rd0_ram_addr", ram_addr, 32'h4);
    chk("rd0_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    m0_req = 0;
    #1;
    chk("rd0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("rd0_dout", m0_dout, 32'hA000_0004);
    chk("rd0_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    tick();
    chk("rd0_rvalid_drop", {31'd0, m0_rvalid}, 32'd0);

    // Both request continuously: grants 0,0,0,0,1 repeating
    m0_req = 1; m0_addr = 32'h0;
    m1_req = 1; m1_addr = 32'h14; m1_lock = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve_gnt1_%0d", i), {31'd0, m1_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_gnt0_%0d", i), {31'd0, m0_gnt}, (i % 5 == 4) ? 32'd0 : 32'd1);
      tick();
      if (i % 5 == 4) begin
        chk($sformatf("starve_m1_rvalid_%0d", i), {31'd0, m1_rvalid}, 32'd1);
        chk($sformatf("starve_m1_dout_%0d", i), m1_dout, 32'hA000_0005);
        chk($sformatf("starve_m0_quiet_%0d", i), {31'd0, m0_rvalid}, 32'd0);
      end else begin
        chk($sformatf("starve_m0_rvalid_%0d", i), {31'd0, m0_rvalid}, 32'd1);
        chk($sformatf("starve_m0_dout_%0d", i), m0_dout, 32'hA000_0000);
      end
    end
    m0_req = 0; m1_req = 0;
    tick();

    // Locked 3-word write burst while port 0 keeps requesting
    m0_req = 1; m0_addr = 32'h0;
    m1_req = 1; m1_wen = 1; m1_lock = 1; m1_addr = 32'h40; m1_din = 32'h11;
    #1;
    n = 0;
    while (!m1_gnt && n < 10) begin
      tick();
      n++;
    end
    chk("burst_wait_cycles", n, 32'd4);
    for (int k = 0; k < 3; k++) begin
      m1_addr = 32'h40 + 32'(4 * k);
      m1_din  = 32'h11 * 32'(k + 1);
      m1_lock = (k < 2);
      #1;
      chk($sformatf("burst_m0_gnt_%0d", k), {31'd0, m0_gnt}, 32'd0);
      chk($sformatf("burst_m1_gnt_%0d", k), {31'd0, m1_gnt}, 32'd1);
      chk($sformatf("burst_ram_we_%0d", k), {31'd0, ram_we}, 32'd1);
      chk($sformatf("burst_ram_addr_%0d", k), ram_addr, 32'd16 + 32'(k));
      tick();
    end
    m1_req = 0; m1_wen = 0; m1_lock = 0;
    #1;
    chk("burst_after_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("burst_mem16", mem[16], 32'h11);
    chk("burst_mem17", mem[17], 32'h22);
    chk("burst_mem18", mem[18], 32'h33);
    tick();
    m0_req = 0;
    tick();

    // Lock timeout: 1 grant from IDLE plus 16 counted grants under lock
    m1_req = 1; m1_wen = 0; m1_lock = 1; m1_addr = 32'h8;
    #1;
    chk("lockto_first_gnt", {31'd0, m1_gnt}, 32'd1);
    tick();
    m0_req = 1;
    #1;
    n = 1;
    while (m1_gnt && n < 40) begin
      if (m0_gnt) chk("lockto_m0_blocked", {31'd0, m0_gnt}, 32'd0);
      n++;
      tick();
    end
    chk("lockto_grant_count", n, 32'd17);
    chk("lockto_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("lockto_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    m0_req = 0; m1_req = 0; m1_lock = 0;
    tick();
    tick();

    // Port 0 write then port 1 read-back of the same word
    m0_req = 1; m0_wen = 1; m0_addr = 32'h20; m0_din = 32'hDEAD_BEEF;
    #1;
    chk("wr_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("wr_ram_we", {31'd0, ram_we}, 32'd1);
    chk("wr_ram_addr", ram_addr, 32'h8);
    chk("wr_ram_din", ram_din, 32'hDEAD_BEEF);
    tick();
    m0_req = 0; m0_wen = 0;
    m1_req = 1; m1_wen = 0; m1_addr = 32'h20;
    #1;
    chk("wr_no_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rb_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("rb_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    m1_req = 0;
    #1;
    chk("rb_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("rb_m1_dout", m1_dout, 32'hDEAD_BEEF);
    chk("rb_ram_we_idle", {31'd0, ram_we}, 32'd0);
    tick();

    // Reset in the cycle after a port-0 read grant drops the return
    m0_req = 1; m0_addr = 32'h10;
    #1;
    chk("rstrd_gnt", {31'd0, m0_gnt}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstrd_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rstrd_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rstrd_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    tick();
    chk("rstrd_rvalid_hold", {31'd0, m0_rvalid}, 32'd0);
    rst = 1'b0; m0_req = 0;
    tick();
    chk("rstrd_rvalid_after", {31'd0, m0_rvalid}, 32'd0);
    m0_req = 1; m1_req = 1; m1_lock = 0;
    #1;
    chk("rstrd_idle_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("rstrd_idle_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    m0_req = 0; m1_req = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
